// File: rtl/rob_multi_retire_pkg.sv
// Shared types and constants for the multi-retire reorder buffer.
//   ROB_ENTRY_t  : what dispatch hands the ROB for one instruction.
//   ROB_RETIRE_t : what one retire lane hands the commit stage.
//   opcode_e     : major opcodes the ROB has to recognise at retire.
//   writes_rd()  : whether a retiring entry updates an architectural rd.
package rob_multi_retire_pkg;

  localparam int ROB_ADDR_WIDTH = 32;
  localparam int ROB_PHY_WIDTH  = 6;
  localparam int ARCH_W         = 5;
  localparam int OPC_W          = 7;

  typedef enum logic [OPC_W-1:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [ARCH_W-1:0]        rd_arch;
    logic [ROB_PHY_WIDTH-1:0] rd_phy_old;
    logic [ROB_PHY_WIDTH-1:0] rd_phy_new;
    logic [OPC_W-1:0]         opcode;
  } ROB_ENTRY_t;

  typedef struct packed {
    logic [ARCH_W-1:0]        rd_arch;
    logic [ROB_PHY_WIDTH-1:0] phy_old;
    logic [ROB_PHY_WIDTH-1:0] phy_new;
    logic                     rd_we;
    logic                     is_store;
  } ROB_RETIRE_t;

  // Stores and branches have no destination; x0 writes are discarded.
  function automatic logic writes_rd(input ROB_ENTRY_t e);
    return (e.rd_arch != '0) && (e.opcode != OPC_STORE) && (e.opcode != OPC_BRANCH);
  endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Retire lane selection for the head window of the ROB.
//   win_valid/win_done/win_misp : state of entries head+0 .. head+RETIRE_W-1
//   lane_mask    : lanes that retire this cycle (always a contiguous low run)
//   lane_cnt     : number of retiring lanes
//   redirect_sel : the last retiring lane is a mispredicted branch
// Purely combinational.
module rob_retire_select
  import rob_multi_retire_pkg::*;
#(
  parameter  int RETIRE_W = 2,
  localparam int CNT_W    = $clog2(RETIRE_W + 1)
) (
  input  logic [RETIRE_W-1:0] win_valid,
  input  logic [RETIRE_W-1:0] win_done,
  input  logic [RETIRE_W-1:0] win_misp,
  output logic [RETIRE_W-1:0] lane_mask,
  output logic [CNT_W-1:0]    lane_cnt,
  output logic                redirect_sel
);

  always_comb begin
    logic go;
    lane_mask    = '0;
    lane_cnt     = '0;
    redirect_sel = 1'b0;
    go           = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (go && win_valid[i] && win_done[i]) begin
        lane_mask[i] = 1'b1;
        lane_cnt     = lane_cnt + CNT_W'(1);
        // A mispredicted branch retires but closes the group behind it.
        if (win_misp[i]) begin
          redirect_sel = 1'b1;
          go           = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi_retire.sv
// Reorder buffer with DISPATCH_W-wide dispatch, RETIRE_W-wide in-order
// retire, WB_PORTS writeback ports and full/empty backpressure. The last
// writeback port is the branch port; it carries mispredict and target. A
// mispredicted branch retiring empties the ROB and raises a one-cycle
// registered redirect.
//   clk, rst (sync, active high), flush (external, empties ROB next edge)
//   dispatch_valid/dispatch_entry in, dispatch_ready/dispatch_rob_id out
//   wb_valid/wb_rob_id/wb_mispredict/wb_target in
//   retire_valid/rd_we/is_store/rd_arch/phy_old/phy_new out (combinational)
//   redirect_valid/redirect_pc out (registered)
//   count/empty/full out (occupancy)
module rob_multi_retire #(
  parameter  int NUM_ENTRY  = 16,
  parameter  int DISPATCH_W = 2,
  parameter  int RETIRE_W   = 2,
  parameter  int WB_PORTS   = 3,
  parameter  int PHY_WIDTH  = rob_multi_retire_pkg::ROB_PHY_WIDTH,
  parameter  int ADDR_WIDTH = rob_multi_retire_pkg::ROB_ADDR_WIDTH,
  localparam int ID_W       = $clog2(NUM_ENTRY)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic [DISPATCH_W-1:0]                         dispatch_valid,
  input  rob_multi_retire_pkg::ROB_ENTRY_t [DISPATCH_W-1:0] dispatch_entry,
  output logic                                          dispatch_ready,
  output logic [DISPATCH_W-1:0][ID_W-1:0]               dispatch_rob_id,
  input  logic [WB_PORTS-1:0]                           wb_valid,
  input  logic [WB_PORTS-1:0][ID_W-1:0]                 wb_rob_id,
  input  logic [WB_PORTS-1:0]                           wb_mispredict,
  input  logic [WB_PORTS-1:0][ADDR_WIDTH-1:0]           wb_target,
  output logic [RETIRE_W-1:0]                           retire_valid,
  output logic [RETIRE_W-1:0]                           retire_rd_we,
  output logic [RETIRE_W-1:0]                           retire_is_store,
  output logic [RETIRE_W-1:0][4:0]                      retire_rd_arch,
  output logic [RETIRE_W-1:0][PHY_WIDTH-1:0]            retire_phy_old,
  output logic [RETIRE_W-1:0][PHY_WIDTH-1:0]            retire_phy_new,
  output logic                                          redirect_valid,
  output logic [ADDR_WIDTH-1:0]                         redirect_pc,
  output logic [ID_W:0]                                 count,
  output logic                                          empty,
  output logic                                          full
);
  import rob_multi_retire_pkg::*;

  localparam int PTR_W  = ID_W + 1;
  localparam int RCNT_W = $clog2(RETIRE_W + 1);
  localparam int BR_P   = WB_PORTS - 1;

  logic [PTR_W-1:0]                     head_q, head_d, tail_q, tail_d;
  logic [NUM_ENTRY-1:0]                 valid_q, valid_d, done_q, done_d, misp_q, misp_d;
  ROB_ENTRY_t [NUM_ENTRY-1:0]           entry_q, entry_d;
  logic [NUM_ENTRY-1:0][ADDR_WIDTH-1:0] target_q, target_d;
  logic                                 redirect_valid_q, redirect_valid_d;
  logic [ADDR_WIDTH-1:0]                redirect_pc_q, redirect_pc_d;

  logic [PTR_W-1:0]                     disp_cnt;
  logic [RETIRE_W-1:0]                  win_valid, win_done, win_misp;
  logic [RETIRE_W-1:0][ID_W-1:0]        win_idx;
  logic [RETIRE_W-1:0]                  ret_mask;
  logic [RCNT_W-1:0]                    ret_cnt;
  logic                                 ret_redirect;
  logic [ADDR_WIDTH-1:0]                sel_target;
  ROB_RETIRE_t [RETIRE_W-1:0]           ret_info;

  // Only the branch port's mispredict/target fields carry meaning.
  logic unused_wb;
  assign unused_wb = ^{wb_mispredict[WB_PORTS-2:0], wb_target[WB_PORTS-2:0]};

  // Occupancy; the wrap bit distinguishes full from empty.
  assign count          = tail_q - head_q;
  assign empty          = (head_q == tail_q);
  assign full           = (head_q[ID_W-1:0] == tail_q[ID_W-1:0]) && (head_q[ID_W] != tail_q[ID_W]);
  assign dispatch_ready = (int'(count) + DISPATCH_W) <= NUM_ENTRY;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  // Valid lanes are packed onto consecutive ids starting at tail.
  always_comb begin
    logic [PTR_W-1:0] k;
    k = '0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      dispatch_rob_id[l] = '0;
      if (dispatch_valid[l]) begin
        dispatch_rob_id[l] = tail_q[ID_W-1:0] + k[ID_W-1:0];
        k = k + PTR_W'(1);
      end
    end
    disp_cnt = k;
  end

  always_comb begin
    for (int i = 0; i < RETIRE_W; i++) begin
      win_idx[i]   = head_q[ID_W-1:0] + ID_W'(i);
      win_valid[i] = valid_q[win_idx[i]];
      win_done[i]  = done_q[win_idx[i]];
      win_misp[i]  = misp_q[win_idx[i]];
    end
  end

  rob_retire_select #(
    .RETIRE_W (RETIRE_W)
  ) u_sel (
    .win_valid    (win_valid),
    .win_done     (win_done),
    .win_misp     (win_misp),
    .lane_mask    (ret_mask),
    .lane_cnt     (ret_cnt),
    .redirect_sel (ret_redirect)
  );

  always_comb begin
    sel_target = '0;
    ret_info   = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (ret_mask[i]) begin
        ret_info[i].rd_arch  = entry_q[win_idx[i]].rd_arch;
        ret_info[i].phy_old  = entry_q[win_idx[i]].rd_phy_old;
        ret_info[i].phy_new  = entry_q[win_idx[i]].rd_phy_new;
        ret_info[i].rd_we    = writes_rd(entry_q[win_idx[i]]);
        ret_info[i].is_store = (entry_q[win_idx[i]].opcode == OPC_STORE);
        if (win_misp[i]) sel_target = target_q[win_idx[i]];
      end
    end
  end

  always_comb begin
    retire_valid = ret_mask;
    for (int i = 0; i < RETIRE_W; i++) begin
      retire_rd_we[i]    = ret_info[i].rd_we;
      retire_is_store[i] = ret_info[i].is_store;
      retire_rd_arch[i]  = ret_info[i].rd_arch;
      retire_phy_old[i]  = ret_info[i].phy_old;
      retire_phy_new[i]  = ret_info[i].phy_new;
    end
  end

  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    valid_d          = valid_q;
    done_d           = done_q;
    misp_d           = misp_q;
    entry_d          = entry_q;
    target_d         = target_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
      misp_d  = '0;
    end else if (ret_redirect) begin
      // Everything younger than the branch is wrong-path: drop it all,
      // including whatever dispatch is offered this cycle.
      head_d           = '0;
      tail_d           = '0;
      valid_d          = '0;
      done_d           = '0;
      misp_d           = '0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = sel_target;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && valid_q[wb_rob_id[p]]) begin
          done_d[wb_rob_id[p]] = 1'b1;
          if (p == BR_P) begin
            misp_d[wb_rob_id[p]]   = wb_mispredict[p];
            target_d[wb_rob_id[p]] = wb_target[p];
          end
        end
      end
      for (int i = 0; i < RETIRE_W; i++) begin
        if (ret_mask[i]) begin
          valid_d[win_idx[i]] = 1'b0;
          done_d[win_idx[i]]  = 1'b0;
          misp_d[win_idx[i]]  = 1'b0;
        end
      end
      head_d = head_q + PTR_W'(ret_cnt);
      if (dispatch_ready) begin
        for (int l = 0; l < DISPATCH_W; l++) begin
          if (dispatch_valid[l]) begin
            valid_d[dispatch_rob_id[l]] = 1'b1;
            done_d[dispatch_rob_id[l]]  = 1'b0;
            misp_d[dispatch_rob_id[l]]  = 1'b0;
            entry_d[dispatch_rob_id[l]] = dispatch_entry[l];
          end
        end
        tail_d = tail_q + disp_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      valid_q          <= '0;
      done_q           <= '0;
      misp_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      valid_q          <= valid_d;
      done_q           <= done_d;
      misp_q           <= misp_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    entry_q  <= entry_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_rob_multi_retire.sv
module tb_rob_multi_retire;
  import rob_multi_retire_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, flush;
  logic [1:0]           dispatch_valid;
  ROB_ENTRY_t [1:0]     dispatch_entry;
  logic                 dispatch_ready;
  logic [1:0][3:0]      dispatch_rob_id;
  logic [2:0]           wb_valid;
  logic [2:0][3:0]      wb_rob_id;
  logic [2:0]           wb_mispredict;
  logic [2:0][31:0]     wb_target;
  logic [1:0]           retire_valid, retire_rd_we, retire_is_store;
  logic [1:0][4:0]      retire_rd_arch;
  logic [1:0][5:0]      retire_phy_old, retire_phy_new;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [4:0]           count;
  logic                 empty, full;

  rob_multi_retire dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_entry(dispatch_entry),
    .dispatch_ready(dispatch_ready), .dispatch_rob_id(dispatch_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_mispredict(wb_mispredict),
    .wb_target(wb_target),
    .retire_valid(retire_valid), .retire_rd_we(retire_rd_we),
    .retire_is_store(retire_is_store), .retire_rd_arch(retire_rd_arch),
    .retire_phy_old(retire_phy_old), .retire_phy_new(retire_phy_new),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] dv;
    logic [2:0] wbv;
    int         w0, w1, w2;
    int         cnt;
    logic       rdy, fl, em;
    logic [1:0] rv;
    int         i0, i1;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  function automatic vec_t mkv(logic [1:0] dv, logic [2:0] wbv, int w0, int w1, int w2,
                               int cnt, logic rdy, logic fl, logic em, logic [1:0] rv,
                               int i0, int i1);
    vec_t v;
    v.dv = dv; v.wbv = wbv; v.w0 = w0; v.w1 = w1; v.w2 = w2;
    v.cnt = cnt; v.rdy = rdy; v.fl = fl; v.em = em; v.rv = rv; v.i0 = i0; v.i1 = i1;
    return v;
  endfunction

  function automatic ROB_ENTRY_t ent(logic [4:0] rd, logic [5:0] po, logic [5:0] pn,
                                     logic [6:0] op);
    ROB_ENTRY_t e;
    e.rd_arch = rd; e.rd_phy_old = po; e.rd_phy_new = pn; e.opcode = op;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic idle();
    flush          = 1'b0;
    dispatch_valid = '0;
    wb_valid       = '0;
    wb_mispredict  = '0;
    wb_rob_id      = '0;
    wb_target      = '0;
    dispatch_entry[0] = ent(5'd1, 6'd0, 6'd0, OPC_OP);
    dispatch_entry[1] = ent(5'd2, 6'd0, 6'd0, OPC_OP);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic reset_checks(string tag);
    @(negedge clk);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".ready"}, 32'(dispatch_ready), 32'd1);
    chk({tag, ".redir_v"}, 32'(redirect_valid), 32'd0);
    chk({tag, ".redir_pc"}, 32'(redirect_pc), 32'd0);
    chk({tag, ".retire_v"}, 32'(retire_valid), 32'd0);
    next_cycle();
  endtask

  task automatic set_wb(logic [2:0] v, int i0, int i1, int i2, logic misp, logic [31:0] tgt);
    wb_valid         = v;
    wb_rob_id[0]     = 4'(i0);
    wb_rob_id[1]     = 4'(i1);
    wb_rob_id[2]     = 4'(i2);
    wb_mispredict    = {misp, 2'b00};
    wb_target[2]     = tgt;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    // Fill, hold while full, out-of-order completion, wrap-around allocation.
    tv[0]  = mkv(2'b11, 3'b000, 0, 0, 0,  0, 1, 0, 1, 2'b00,  0,  1);
    tv[1]  = mkv(2'b11, 3'b000, 0, 0, 0,  2, 1, 0, 0, 2'b00,  2,  3);
    tv[2]  = mkv(2'b11, 3'b000, 0, 0, 0,  4, 1, 0, 0, 2'b00,  4,  5);
    tv[3]  = mkv(2'b11, 3'b000, 0, 0, 0,  6, 1, 0, 0, 2'b00,  6,  7);
    tv[4]  = mkv(2'b11, 3'b000, 0, 0, 0,  8, 1, 0, 0, 2'b00,  8,  9);
    tv[5]  = mkv(2'b11, 3'b000, 0, 0, 0, 10, 1, 0, 0, 2'b00, 10, 11);
    tv[6]  = mkv(2'b11, 3'b000, 0, 0, 0, 12, 1, 0, 0, 2'b00, 12, 13);
    tv[7]  = mkv(2'b11, 3'b000, 0, 0, 0, 14, 1, 0, 0, 2'b00, 14, 15);
    tv[8]  = mkv(2'b11, 3'b000, 0, 0, 0, 16, 0, 1, 0, 2'b00,  0,  1);
    tv[9]  = mkv(2'b00, 3'b010, 0, 1, 0, 16, 0, 1, 0, 2'b00,  0,  0);
    tv[10] = mkv(2'b00, 3'b001, 0, 0, 0, 16, 0, 1, 0, 2'b00,  0,  0);
    tv[11] = mkv(2'b00, 3'b000, 0, 0, 0, 16, 0, 1, 0, 2'b11,  0,  0);
    tv[12] = mkv(2'b00, 3'b000, 0, 0, 0, 14, 1, 0, 0, 2'b00,  0,  0);
    tv[13] = mkv(2'b01, 3'b000, 0, 0, 0, 14, 1, 0, 0, 2'b00,  0,  0);
    tv[14] = mkv(2'b10, 3'b000, 0, 0, 0, 15, 0, 0, 0, 2'b00,  0,  1);
    tv[15] = mkv(2'b00, 3'b111, 2, 3, 4, 15, 0, 0, 0, 2'b00,  0,  0);
    tv[16] = mkv(2'b00, 3'b000, 0, 0, 0, 15, 0, 0, 0, 2'b11,  0,  0);
    tv[17] = mkv(2'b00, 3'b000, 0, 0, 0, 13, 1, 0, 0, 2'b01,  0,  0);
    tv[18] = mkv(2'b00, 3'b000, 0, 0, 0, 12, 1, 0, 0, 2'b00,  0,  0);

    do_reset();
    reset_checks("reset0");

    for (int i = 0; i < NV; i++) begin
      idle();
      dispatch_valid = tv[i].dv;
      set_wb(tv[i].wbv, tv[i].w0, tv[i].w1, tv[i].w2, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d.count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("v%0d.ready", i), 32'(dispatch_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d.full", i), 32'(full), 32'(tv[i].fl));
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(tv[i].em));
      chk($sformatf("v%0d.retire_v", i), 32'(retire_valid), 32'(tv[i].rv));
      chk($sformatf("v%0d.id0", i), 32'(dispatch_rob_id[0]), 32'(tv[i].i0));
      chk($sformatf("v%0d.id1", i), 32'(dispatch_rob_id[1]), 32'(tv[i].i1));
      next_cycle();
    end

    // Mispredict at retire: ids 2..5 done, id 3 mispredicted to 0x80.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      dispatch_valid    = 2'b11;
      dispatch_entry[0] = ent(5'd3, 6'(10 + 2*c), 6'(40 + 2*c), OPC_OP);
      dispatch_entry[1] = ent(5'd4, 6'(11 + 2*c), 6'(41 + 2*c), (c == 1) ? OPC_BRANCH : OPC_OP);
      next_cycle();
    end
    idle(); set_wb(3'b111, 2, 4, 3, 1'b1, 32'h80); next_cycle();
    idle(); set_wb(3'b001, 5, 0, 0, 1'b0, 32'h0);  next_cycle();
    idle(); set_wb(3'b011, 0, 1, 0, 1'b0, 32'h0);
    @(negedge clk);
    chk("mp.pre_retire_v", 32'(retire_valid), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("mp.g0_retire_v", 32'(retire_valid), 32'b11);
    chk("mp.g0_phy_old0", 32'(retire_phy_old[0]), 32'd10);
    chk("mp.g0_phy_old1", 32'(retire_phy_old[1]), 32'd11);
    chk("mp.g0_redir_v", 32'(redirect_valid), 32'd0);
    next_cycle();
    idle(); dispatch_valid = 2'b11;
    @(negedge clk);
    chk("mp.g1_retire_v", 32'(retire_valid), 32'b11);
    chk("mp.g1_phy_old0", 32'(retire_phy_old[0]), 32'd12);
    chk("mp.g1_phy_old1", 32'(retire_phy_old[1]), 32'd13);
    chk("mp.g1_count", 32'(count), 32'd4);
    next_cycle();
    idle(); set_wb(3'b001, 4, 0, 0, 1'b0, 32'h0);
    @(negedge clk);
    chk("mp.redir_v", 32'(redirect_valid), 32'd1);
    chk("mp.redir_pc", 32'(redirect_pc), 32'h80);
    chk("mp.empty", 32'(empty), 32'd1);
    chk("mp.count", 32'(count), 32'd0);
    chk("mp.post_retire_v", 32'(retire_valid), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("mp.redir_pulse", 32'(redirect_valid), 32'd0);
    chk("mp.stale_retire_v", 32'(retire_valid), 32'd0);
    chk("mp.still_empty", 32'(empty), 32'd1);
    next_cycle();

    // External flush during dispatch and writeback.
    idle(); dispatch_valid = 2'b11; next_cycle();
    idle(); dispatch_valid = 2'b11; flush = 1'b1; set_wb(3'b011, 0, 1, 0, 1'b0, 32'h0);
    @(negedge clk);
    chk("fl.pre_count", 32'(count), 32'd2);
    next_cycle();
    idle();
    @(negedge clk);
    chk("fl.count", 32'(count), 32'd0);
    chk("fl.empty", 32'(empty), 32'd1);
    chk("fl.retire_v", 32'(retire_valid), 32'd0);
    next_cycle();
    idle(); dispatch_valid = 2'b01;
    @(negedge clk);
    chk("fl.retire_v2", 32'(retire_valid), 32'd0);
    chk("fl.id0", 32'(dispatch_rob_id[0]), 32'd0);
    next_cycle();

    // Reset mid-operation also clears the held redirect target.
    do_reset();
    reset_checks("reset1");

    // STORE and x0 destinations.
    idle(); dispatch_valid = 2'b11;
    dispatch_entry[0] = ent(5'd5, 6'd20, 6'd30, OPC_STORE);
    dispatch_entry[1] = ent(5'd0, 6'd21, 6'd31, OPC_OP);
    next_cycle();
    idle(); dispatch_valid = 2'b11;
    dispatch_entry[0] = ent(5'd7, 6'd22, 6'd32, OPC_BRANCH);
    dispatch_entry[1] = ent(5'd9, 6'd23, 6'd33, OPC_OP);
    next_cycle();
    idle(); set_wb(3'b111, 0, 1, 2, 1'b0, 32'h0); next_cycle();
    idle(); set_wb(3'b001, 3, 0, 0, 1'b0, 32'h0);
    @(negedge clk);
    chk("st.g0_retire_v", 32'(retire_valid), 32'b11);
    chk("st.g0_is_store", 32'(retire_is_store), 32'b01);
    chk("st.g0_rd_we", 32'(retire_rd_we), 32'b00);
    next_cycle();
    idle();
    @(negedge clk);
    chk("st.g1_retire_v", 32'(retire_valid), 32'b11);
    chk("st.g1_is_store", 32'(retire_is_store), 32'b00);
    chk("st.g1_rd_we", 32'(retire_rd_we), 32'b10);
    chk("st.g1_rd_arch1", 32'(retire_rd_arch[1]), 32'd9);
    chk("st.g1_phy_new1", 32'(retire_phy_new[1]), 32'd33);
    next_cycle();
    @(negedge clk);
    chk("st.empty", 32'(empty), 32'd1);
    next_cycle();

    // Fill, drain completely, refill: wrap bit must keep full/empty right.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle(); dispatch_valid = 2'b11; next_cycle();
    end
    for (int j = 0; j < 8; j++) begin
      idle(); set_wb(3'b011, 2*j, 2*j + 1, 0, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("wr.drain%0d_retire_v", j), 32'(retire_valid), (j == 0) ? 32'd0 : 32'b11);
      chk($sformatf("wr.drain%0d_count", j), 32'(count), (j <= 1) ? 32'd16 : 32'(16 - 2*(j-1)));
      next_cycle();
    end
    idle(); next_cycle();
    @(negedge clk);
    chk("wr.drained_empty", 32'(empty), 32'd1);
    chk("wr.drained_count", 32'(count), 32'd0);
    chk("wr.drained_full", 32'(full), 32'd0);
    next_cycle();
    for (int c = 0; c < 8; c++) begin
      idle(); dispatch_valid = 2'b11;
      @(negedge clk);
      chk($sformatf("wr.refill%0d_id0", c), 32'(dispatch_rob_id[0]), 32'(2*c));
      chk($sformatf("wr.refill%0d_id1", c), 32'(dispatch_rob_id[1]), 32'(2*c + 1));
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk("wr.full", 32'(full), 32'd1);
    chk("wr.count", 32'(count), 32'd16);
    chk("wr.ready", 32'(dispatch_ready), 32'd0);
    next_cycle();

    do_reset();
    reset_checks("reset2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
